// File: rtl/alu_share_pkg.sv
// ---------------------------------------------------------------------------
// alu_share_pkg
// Shared definitions for the ALU sharing arbiter: opcode encodings understood
// by the shared ALU, the arbiter FSM state encoding and requester ids.
// Used by alu_share_arbiter and rr_arb2.
// ---------------------------------------------------------------------------
package alu_share_pkg;

    // Opcodes understood by the shared ALU. The arbiter forwards them
    // untouched; only ADD and SUB produce a meaningful overflow flag.
    localparam logic [2:0] OP_AND = 3'b000;
    localparam logic [2:0] OP_OR  = 3'b001;
    localparam logic [2:0] OP_ADD = 3'b010;
    localparam logic [2:0] OP_XOR = 3'b011;
    localparam logic [2:0] OP_NOR = 3'b100;
    localparam logic [2:0] OP_SRL = 3'b101;
    localparam logic [2:0] OP_SUB = 3'b110;
    localparam logic [2:0] OP_SLT = 3'b111;

    // Arbiter FSM: wait for a request, drive the ALU for one cycle,
    // then hold the registered result until the owner takes it.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } arb_state_e;

    // Requester ids as stored in the grant register.
    localparam logic REQ_ID0 = 1'b0;
    localparam logic REQ_ID1 = 1'b1;

endpackage

// File: rtl/rr_arb2.sv
// ---------------------------------------------------------------------------
// rr_arb2
// Purely combinational two-input round-robin picker. The history register
// (last granted id) lives in the parent.
//
// Ports:
//   valid0_i  requester 0 wants the resource
//   valid1_i  requester 1 wants the resource
//   last_i    id of the requester granted most recently
//   grant_o   one-hot grant, bit N = requester N wins (zero if no request)
// ---------------------------------------------------------------------------
module rr_arb2
    import alu_share_pkg::*;
(
    input  logic       valid0_i,
    input  logic       valid1_i,
    input  logic       last_i,
    output logic [1:0] grant_o
);

    // On a tie the requester that did not win last time goes first.
    always_comb begin
        grant_o = 2'b00;
        if (valid0_i && valid1_i) begin
            grant_o = (last_i == REQ_ID1) ? 2'b01 : 2'b10;
        end else if (valid0_i) begin
            grant_o = 2'b01;
        end else if (valid1_i) begin
            grant_o = 2'b10;
        end
    end

endmodule

// File: rtl/alu_share_arbiter.sv
// ---------------------------------------------------------------------------
// alu_share_arbiter
// Shares one combinational ALU between two valid/ready requesters. One
// operation is in flight at a time: accept (IDLE), drive the ALU for one
// cycle (EXEC), then present the registered result to the owner (RESP).
//
// Optional feature: define ALU_ARB_STATS_EN to add per-requester accept
// counters grant_cnt0/grant_cnt1 (CNT_W bits, wrapping).
//
// Ports:
//   clk, rst_n                 clock (rising edge), async active-low reset
//   reqN_valid/ready/op/a/b    request handshake and operands, N = 0,1
//   respN_valid/ready          response handshake, N = 0,1
//   resp_res/zero/overflow     registered ALU outputs, shared by both
//   alu_a/alu_b/alu_op         operands to the ALU (zero outside EXEC)
//   alu_res/zero/overflow      ALU outputs
//   grant_cnt0/grant_cnt1      accept counters (ALU_ARB_STATS_EN only)
// ---------------------------------------------------------------------------
module alu_share_arbiter
    import alu_share_pkg::*;
#(
    parameter int DATA_W = 32
`ifdef ALU_ARB_STATS_EN
    ,
    parameter int CNT_W  = 16
`endif
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic [2:0]        req0_op,
    input  logic [DATA_W-1:0] req0_a,
    input  logic [DATA_W-1:0] req0_b,
    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic [2:0]        req1_op,
    input  logic [DATA_W-1:0] req1_a,
    input  logic [DATA_W-1:0] req1_b,
    output logic              resp0_valid,
    input  logic              resp0_ready,
    output logic              resp1_valid,
    input  logic              resp1_ready,
    output logic [DATA_W-1:0] resp_res,
    output logic              resp_zero,
    output logic              resp_overflow,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic [2:0]        alu_op,
    input  logic [DATA_W-1:0] alu_res,
    input  logic              alu_zero,
    input  logic              alu_overflow
`ifdef ALU_ARB_STATS_EN
    ,
    output logic [CNT_W-1:0]  grant_cnt0,
    output logic [CNT_W-1:0]  grant_cnt1
`endif
);

    arb_state_e        state_q, state_d;
    // Doubles as the id of the in-flight operation: it is only rewritten
    // on accept, so during EXEC/RESP it names the current owner.
    logic              last_grant_q, last_grant_d;
    logic [2:0]        op_q, op_d;
    logic [DATA_W-1:0] a_q, a_d;
    logic [DATA_W-1:0] b_q, b_d;
    logic [DATA_W-1:0] res_q, res_d;
    logic              zero_q, zero_d;
    logic              ovf_q, ovf_d;

    logic [1:0]        grant;
    logic              accept;
    logic              resp_take;

    rr_arb2 u_rr_arb2 (
        .valid0_i (req0_valid),
        .valid1_i (req1_valid),
        .last_i   (last_grant_q),
        .grant_o  (grant)
    );

    assign accept      = (state_q == IDLE) && (grant != 2'b00);
    assign req0_ready  = accept & grant[0];
    assign req1_ready  = accept & grant[1];

    assign resp0_valid = (state_q == RESP) && (last_grant_q == REQ_ID0);
    assign resp1_valid = (state_q == RESP) && (last_grant_q == REQ_ID1);
    // Only the owner's ready can release the result.
    assign resp_take   = (resp0_valid & resp0_ready) | (resp1_valid & resp1_ready);

    // The ALU sees operands only during EXEC so it idles on zeros otherwise.
    assign alu_a  = (state_q == EXEC) ? a_q  : '0;
    assign alu_b  = (state_q == EXEC) ? b_q  : '0;
    assign alu_op = (state_q == EXEC) ? op_q : 3'b000;

    assign resp_res      = res_q;
    assign resp_zero     = zero_q;
    assign resp_overflow = ovf_q;

    // Next-state logic. RESP returns to IDLE on the response handshake, so
    // a new accept can happen at the earliest one cycle later.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = EXEC;
            EXEC:    state_d = RESP;
            RESP:    if (resp_take) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Datapath next values: latch the winner's request on accept and
    // capture the ALU outputs at the end of the single EXEC cycle.
    always_comb begin
        last_grant_d = last_grant_q;
        op_d         = op_q;
        a_d          = a_q;
        b_d          = b_q;
        res_d        = res_q;
        zero_d       = zero_q;
        ovf_d        = ovf_q;
        if (accept) begin
            last_grant_d = grant[1] ? REQ_ID1 : REQ_ID0;
            op_d         = grant[1] ? req1_op : req0_op;
            a_d          = grant[1] ? req1_a  : req0_a;
            b_d          = grant[1] ? req1_b  : req0_b;
        end
        if (state_q == EXEC) begin
            res_d  = alu_res;
            zero_d = alu_zero;
            ovf_d  = alu_overflow;
        end
    end

    // State and datapath registers. last_grant resets to requester 1 so
    // requester 0 wins the first tie.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            last_grant_q <= REQ_ID1;
            op_q         <= 3'b000;
            a_q          <= '0;
            b_q          <= '0;
            res_q        <= '0;
            zero_q       <= 1'b0;
            ovf_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            op_q         <= op_d;
            a_q          <= a_d;
            b_q          <= b_d;
            res_q        <= res_d;
            zero_q       <= zero_d;
            ovf_q        <= ovf_d;
        end
    end

`ifdef ALU_ARB_STATS_EN
    logic [CNT_W-1:0] cnt0_q, cnt0_d;
    logic [CNT_W-1:0] cnt1_q, cnt1_d;

    // Accept counters wrap naturally at 2^CNT_W.
    always_comb begin
        cnt0_d = cnt0_q;
        cnt1_d = cnt1_q;
        if (req0_ready) cnt0_d = cnt0_q + 1'b1;
        if (req1_ready) cnt1_d = cnt1_q + 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt0_q <= '0;
            cnt1_q <= '0;
        end else begin
            cnt0_q <= cnt0_d;
            cnt1_q <= cnt1_d;
        end
    end

    assign grant_cnt0 = cnt0_q;
    assign grant_cnt1 = cnt1_q;
`endif

endmodule

// File: tb/tb_alu_share_arbiter.sv
// ---------------------------------------------------------------------------
// tb_alu_share_arbiter
// Bench for alu_share_arbiter with a behavioural ALU attached. Expected
// responses are hand-computed constants queued per requester at issue time;
// a monitor pops and compares them whenever a response handshake happens.
// Define ALU_ARB_STATS_EN to also exercise the accept counters (CNT_W = 2).
// ---------------------------------------------------------------------------
module tb_alu_share_arbiter;
    import alu_share_pkg::*;

    localparam int DATA_W = 32;
`ifdef ALU_ARB_STATS_EN
    localparam int CNT_W = 2;
`endif

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              req0_valid, req0_ready, req1_valid, req1_ready;
    logic [2:0]        req0_op, req1_op;
    logic [DATA_W-1:0] req0_a, req0_b, req1_a, req1_b;
    logic              resp0_valid, resp0_ready, resp1_valid, resp1_ready;
    logic [DATA_W-1:0] resp_res;
    logic              resp_zero, resp_overflow;
    logic [DATA_W-1:0] alu_a, alu_b, alu_res;
    logic [2:0]        alu_op;
    logic              alu_zero, alu_overflow;
`ifdef ALU_ARB_STATS_EN
    logic [CNT_W-1:0]  grant_cnt0, grant_cnt1;
`endif

    typedef struct {
        logic [31:0] res;
        logic        zero;
        logic        ovf;
    } exp_t;

    exp_t expQ0[$];
    exp_t expQ1[$];
    int   grantLog[$];
    exp_t monE;
    int   checkCount = 0;
    int   passCount  = 0;

    always #5 clk = ~clk;

    alu_share_arbiter #(
        .DATA_W (DATA_W)
`ifdef ALU_ARB_STATS_EN
        ,
        .CNT_W  (CNT_W)
`endif
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .req0_valid    (req0_valid),
        .req0_ready    (req0_ready),
        .req0_op       (req0_op),
        .req0_a        (req0_a),
        .req0_b        (req0_b),
        .req1_valid    (req1_valid),
        .req1_ready    (req1_ready),
        .req1_op       (req1_op),
        .req1_a        (req1_a),
        .req1_b        (req1_b),
        .resp0_valid   (resp0_valid),
        .resp0_ready   (resp0_ready),
        .resp1_valid   (resp1_valid),
        .resp1_ready   (resp1_ready),
        .resp_res      (resp_res),
        .resp_zero     (resp_zero),
        .resp_overflow (resp_overflow),
        .alu_a         (alu_a),
        .alu_b         (alu_b),
        .alu_op        (alu_op),
        .alu_res       (alu_res),
        .alu_zero      (alu_zero),
        .alu_overflow  (alu_overflow)
`ifdef ALU_ARB_STATS_EN
        ,
        .grant_cnt0    (grant_cnt0),
        .grant_cnt1    (grant_cnt1)
`endif
    );

    // Behavioural stand-in for the shared ALU.
    always_comb begin
        alu_res      = '0;
        alu_overflow = 1'b0;
        case (alu_op)
            OP_AND: alu_res = alu_a & alu_b;
            OP_OR:  alu_res = alu_a | alu_b;
            OP_ADD: begin
                alu_res      = alu_a + alu_b;
                alu_overflow = (alu_a[31] == alu_b[31]) && (alu_res[31] != alu_a[31]);
            end
            OP_XOR: alu_res = alu_a ^ alu_b;
            OP_NOR: alu_res = ~(alu_a | alu_b);
            OP_SRL: alu_res = alu_a >> alu_b[4:0];
            OP_SUB: begin
                alu_res      = alu_a - alu_b;
                alu_overflow = (alu_a[31] != alu_b[31]) && (alu_res[31] != alu_a[31]);
            end
            default: alu_res = ($signed(alu_a) < $signed(alu_b)) ? 32'd1 : 32'd0;
        endcase
        alu_zero = (alu_res == '0);
    end

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checkCount++;
        if (actual === expected) passCount++;
        else $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    endtask

    // Issue one request on requester id (called at posedge+1) and hold it
    // until accepted. Returns at posedge+1 just after the accepting edge.
    task automatic applyStimulus(input int id, input logic [2:0] op,
                                 input logic [31:0] a, input logic [31:0] b,
                                 input logic wantResp, input logic [31:0] expRes,
                                 input logic expZero, input logic expOvf);
        exp_t e;
        logic done;
        done  = 1'b0;
        e.res  = expRes;
        e.zero = expZero;
        e.ovf  = expOvf;
        if (wantResp) begin
            if (id == 0) expQ0.push_back(e);
            else         expQ1.push_back(e);
        end
        if (id == 0) begin
            req0_valid = 1'b1; req0_op = op; req0_a = a; req0_b = b;
        end else begin
            req1_valid = 1'b1; req1_op = op; req1_a = a; req1_b = b;
        end
        for (int i = 0; i < 200 && !done; i++) begin
            @(negedge clk);
            if ((id == 0 && req0_ready) || (id == 1 && req1_ready)) done = 1'b1;
        end
        checkOutput($sformatf("req%0d accepted", id), 32'(done), 32'd1);
        @(posedge clk);
        #1;
        if (id == 0) req0_valid = 1'b0;
        else         req1_valid = 1'b0;
    endtask

    // Wait until every queued response has been seen, then realign.
    task automatic waitDrain();
        int n;
        n = 0;
        while ((expQ0.size() + expQ1.size()) != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        checkOutput("scoreboard drained", 32'(expQ0.size() + expQ1.size()), 32'd0);
        @(posedge clk);
        #1;
    endtask

    // Response monitor and grant logger, sampling on the falling edge.
    always @(negedge clk) begin
        if (rst_n) begin
            if (resp0_valid && resp0_ready) begin
                checkOutput("resp one-hot (r0)", 32'(resp1_valid), 32'd0);
                if (expQ0.size() == 0) begin
                    checkOutput("spurious resp0", 32'(resp0_valid), 32'd0);
                end else begin
                    monE = expQ0.pop_front();
                    checkOutput("resp0 res", resp_res, monE.res);
                    checkOutput("resp0 zero", 32'(resp_zero), 32'(monE.zero));
                    checkOutput("resp0 ovf", 32'(resp_overflow), 32'(monE.ovf));
                end
            end
            if (resp1_valid && resp1_ready) begin
                checkOutput("resp one-hot (r1)", 32'(resp0_valid), 32'd0);
                if (expQ1.size() == 0) begin
                    checkOutput("spurious resp1", 32'(resp1_valid), 32'd0);
                end else begin
                    monE = expQ1.pop_front();
                    checkOutput("resp1 res", resp_res, monE.res);
                    checkOutput("resp1 zero", 32'(resp_zero), 32'(monE.zero));
                    checkOutput("resp1 ovf", 32'(resp_overflow), 32'(monE.ovf));
                end
            end
            if (req0_valid && req0_ready) grantLog.push_back(0);
            if (req1_valid && req1_ready) grantLog.push_back(1);
        end
    end

    // Hard stop in case something hangs outside a bounded wait.
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int expG[5];
        int nViol;
        expG = '{0, 1, 0, 1, 0};
        req0_valid = 1'b0; req0_op = 3'b000; req0_a = '0; req0_b = '0;
        req1_valid = 1'b0; req1_op = 3'b000; req1_a = '0; req1_b = '0;
        resp0_ready = 1'b1;
        resp1_ready = 1'b1;

        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        // Reset values
        @(negedge clk);
        checkOutput("reset resp0_valid", 32'(resp0_valid), 32'd0);
        checkOutput("reset resp1_valid", 32'(resp1_valid), 32'd0);
        checkOutput("reset resp_res", resp_res, 32'd0);
        checkOutput("reset resp_zero", 32'(resp_zero), 32'd0);
        checkOutput("reset resp_overflow", 32'(resp_overflow), 32'd0);
        checkOutput("reset alu_a", alu_a, 32'd0);
        checkOutput("reset alu_b", alu_b, 32'd0);
        checkOutput("reset alu_op", 32'(alu_op), 32'd0);
        checkOutput("idle req0_ready", 32'(req0_ready), 32'd0);
`ifdef ALU_ARB_STATS_EN
        checkOutput("reset grant_cnt0", 32'(grant_cnt0), 32'd0);
        checkOutput("reset grant_cnt1", 32'(grant_cnt1), 32'd0);
`endif
        @(posedge clk);
        #1;

        // Simultaneous pair from reset (req0 first), lone req0, then a
        // pair where req1 is preferred.
        $display("[TB] simultaneous requests");
        grantLog.delete();
        fork
            applyStimulus(0, OP_SUB, 32'd5, 32'd5, 1'b1, 32'd0, 1'b1, 1'b0);
            applyStimulus(1, OP_AND, 32'hF0, 32'h0F, 1'b1, 32'd0, 1'b1, 1'b0);
        join
        applyStimulus(0, OP_OR, 32'h12, 32'h21, 1'b1, 32'h33, 1'b0, 1'b0);
        fork
            applyStimulus(0, OP_XOR, 32'hFF, 32'h0F, 1'b1, 32'hF0, 1'b0, 1'b0);
            applyStimulus(1, OP_NOR, 32'd0, 32'd0, 1'b1, 32'hFFFFFFFF, 1'b0, 1'b0);
        join
        waitDrain();
        checkOutput("grant log length", 32'(grantLog.size()), 32'd5);
        for (int i = 0; i < 5 && i < grantLog.size(); i++)
            checkOutput($sformatf("grant order %0d", i), 32'(grantLog[i]), 32'(expG[i]));

        // Single request with latency: ALU driven one cycle after accept,
        // response valid the cycle after that.
        $display("[TB] single request latency");
        applyStimulus(0, OP_ADD, 32'h7FFFFFFF, 32'd1, 1'b1, 32'h80000000, 1'b0, 1'b1);
        @(negedge clk);
        checkOutput("exec alu_a", alu_a, 32'h7FFFFFFF);
        checkOutput("exec alu_b", alu_b, 32'd1);
        checkOutput("exec alu_op", 32'(alu_op), 32'(OP_ADD));
        checkOutput("exec resp0_valid", 32'(resp0_valid), 32'd0);
        @(negedge clk);
        checkOutput("N+2 resp0_valid", 32'(resp0_valid), 32'd1);
        waitDrain();

        // Response backpressure on requester 1 while requester 0 waits.
        $display("[TB] response backpressure");
        resp1_ready = 1'b0;
        applyStimulus(1, OP_SLT, 32'd3, 32'd9, 1'b1, 32'd1, 1'b0, 1'b0);
        fork
            applyStimulus(0, OP_AND, 32'hFFFF0000, 32'h0F0F0F0F, 1'b1, 32'h0F0F0000, 1'b0, 1'b0);
        join_none
        @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checkOutput($sformatf("hold resp1_valid %0d", i), 32'(resp1_valid), 32'd1);
            checkOutput($sformatf("hold resp_res %0d", i), resp_res, 32'd1);
            checkOutput($sformatf("hold req0_ready %0d", i), 32'(req0_ready), 32'd0);
        end
        @(posedge clk);
        #1 resp1_ready = 1'b1;
        wait fork;
        waitDrain();

        // Asynchronous reset while an operation is in EXEC.
        $display("[TB] reset during EXEC");
        applyStimulus(0, OP_SRL, 32'hF0000000, 32'd4, 1'b0, 32'd0, 1'b0, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("in-reset alu_a", alu_a, 32'd0);
        checkOutput("in-reset resp0_valid", 32'(resp0_valid), 32'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checkOutput($sformatf("post-reset resp0_valid %0d", i), 32'(resp0_valid), 32'd0);
        end
        @(posedge clk);
        #1;
        applyStimulus(0, OP_SRL, 32'hF0000000, 32'd4, 1'b1, 32'h0F000000, 1'b0, 1'b0);
        waitDrain();

        // Continuous contention: 20 accepts must alternate strictly.
        $display("[TB] continuous contention");
        grantLog.delete();
        fork
            begin
                for (int i = 0; i < 10; i++)
                    applyStimulus(0, OP_ADD, 32'(i), 32'(i), 1'b1, 32'(2 * i), (i == 0), 1'b0);
            end
            begin
                for (int j = 0; j < 10; j++)
                    applyStimulus(1, OP_SUB, 32'd100, 32'(j), 1'b1, 32'(100 - j), 1'b0, 1'b0);
            end
        join
        waitDrain();
        checkOutput("contention accepts", 32'(grantLog.size()), 32'd20);
        nViol = 0;
        for (int i = 1; i < grantLog.size(); i++)
            if (grantLog[i] == grantLog[i-1]) nViol++;
        checkOutput("grant alternation violations", 32'(nViol), 32'd0);

`ifdef ALU_ARB_STATS_EN
        // Counter wrap with CNT_W = 2: five accepts leave count 1.
        $display("[TB] grant counters");
        rst_n = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        for (int i = 0; i < 5; i++)
            applyStimulus(0, OP_ADD, 32'd1, 32'd1, 1'b1, 32'd2, 1'b0, 1'b0);
        waitDrain();
        checkOutput("grant_cnt0 wrap", 32'(grant_cnt0), 32'd1);
        checkOutput("grant_cnt1", 32'(grant_cnt1), 32'd0);
`endif

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
